uart_tx_fifo: RTL and testbench

//  Byte FIFO and launch sequencer directly upstream of the uart transmitter.

---
 rtl/uart_tx_fifo.sv | 117 +++++++++++
 tb/tb_uart_tx_fifo.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO and launch sequencer feeding a UART transmitter: buffers pushed bytes and
// launches one frame at a time. Optional `UART_TX_FIFO_LEVEL_EN adds a fill-level output.
module uart_tx_fifo #(
  parameter  int DEPTH          = 16,
  parameter  int CLOCKS_PER_BIT = 1,
  localparam int ADDR_W         = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              busy,
  output logic              tx_send,
  output logic [7:0]        tx_byte,
  input  logic              tx_done
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [ADDR_W:0]   level
`endif
);

  // A full frame is 10 bit times; waiting that long after reset lets a frame the
  // transmitter was already sending finish, so its done pulse is never mistaken for ours.
  localparam int HOLD_CYCLES = 10 * CLOCKS_PER_BIT;
  localparam int HOLD_W      = $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {
    HOLDOFF,
    IDLE,
    WAIT
  } state_t;

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic                tx_send_nxt;
  logic [7:0]          tx_byte_nxt;

  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     count;
  logic                push, pop;

  assign full  = (count == (ADDR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign busy  = (state != IDLE);
  assign push  = wr_en && !full;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    tx_send_nxt  = 1'b0;
    tx_byte_nxt  = tx_byte;
    pop          = 1'b0;
    unique case (state)
      HOLDOFF: begin
        if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) state_nxt = IDLE;
        else                                      hold_cnt_nxt = hold_cnt + HOLD_W'(1);
      end
      IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          tx_byte_nxt = mem[rd_ptr];
          tx_send_nxt = 1'b1;
          state_nxt   = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) state_nxt = IDLE;
      end
      default: state_nxt = HOLDOFF;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignments so every register in the
  // block sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= HOLDOFF;
      hold_cnt <= '0;
      tx_send  <= 1'b0;
      tx_byte  <= 8'h00;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      tx_send  <= tx_send_nxt;
      tx_byte  <= tx_byte_nxt;
      overflow <= wr_en && full;
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

`ifdef UART_TX_FIFO_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a behavioural transmitter and line monitor
// surround the DUT, and a queue-based reference model predicts every output each cycle.
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int HOLD  = 10 * CPB;

  logic       clock = 1'b0;
  logic       reset, wr_en, tx_done, line;
  logic [7:0] wr_data;
  logic       full, empty, overflow, busy, tx_send;
  logic [7:0] tx_byte;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  always #5 clock = ~clock;

  uart_tx_fifo #(.DEPTH(DEPTH), .CLOCKS_PER_BIT(CPB)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .busy     (busy),
    .tx_send  (tx_send),
    .tx_byte  (tx_byte),
    .tx_done  (tx_done)
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int unstable = 0;
  int framing_err = 0;

  // reference model state
  logic [7:0] q[$];
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];
  bit         sent_dc[$];
  int         holdoff_left = 0;
  bit         ready = 1'b0;
  logic       exp_send = 1'b0;
  logic       exp_ovf  = 1'b0;
  logic [7:0] exp_byte = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict the edge about to happen from the current inputs, take the edge, then compare.
  task automatic tick();
    bit was_ready, sent, was_full;
    if (reset) begin
      q.delete();
      holdoff_left = HOLD;
      ready    = 1'b0;
      exp_send = 1'b0;
      exp_ovf  = 1'b0;
      exp_byte = 8'h00;
    end else begin
      was_ready = ready;
      was_full  = (q.size() == DEPTH);
      sent      = was_ready && (q.size() != 0);
      exp_ovf   = wr_en && was_full;
      if (sent) begin
        exp_byte = q.pop_front();
        sent_q.push_back(exp_byte);
        sent_dc.push_back(1'b0);
        ready = 1'b0;
      end
      if (wr_en && !was_full) q.push_back(wr_data);
      if (holdoff_left != 0) begin
        holdoff_left--;
        if (holdoff_left == 0) ready = 1'b1;
      end else if (!was_ready && tx_done) begin
        ready = 1'b1;
      end
      exp_send = sent;
    end
    @(posedge clock);
    #2;
    check("empty",    32'(empty),    32'(q.size() == 0));
    check("full",     32'(full),     32'(q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("busy",     32'(busy),     32'(!ready));
    check("tx_send",  32'(tx_send),  32'(exp_send));
    check("tx_byte",  32'(tx_byte),  32'(exp_byte));
`ifdef UART_TX_FIFO_LEVEL_EN
    check("level",    32'(level),    32'(q.size()));
`endif
  endtask

  task automatic push_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy !== 1'b0 || q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    check("drain_in_budget", 32'(n < 2000), 32'(1));
  endtask

  task automatic wait_rx_and_compare();
    int n = 0;
    while (rx_q.size() < sent_q.size() && n < 200) begin
      tick();
      n++;
    end
    check("rx_count", 32'(rx_q.size()), 32'(sent_q.size()));
    for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++)
      if (!sent_dc[i]) check("rx_byte", 32'(rx_q[i]), 32'(sent_q[i]));
    rx_q.delete();
    sent_q.delete();
    sent_dc.delete();
  endtask

  // Behavioural transmitter with no reset: samples its byte input at every bit.
  initial begin : xmtr
    logic [7:0] fb;
    logic [7:0] cur;
    bit         aborted;
    line    = 1'b1;
    tx_done = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      tx_done = 1'b0;
      if (tx_send === 1'b1) begin
        fb      = tx_byte;
        aborted = 1'b0;
        for (int b = 0; b < 10; b++) begin
          if (b == 0)      line = 1'b0;
          else if (b == 9) line = 1'b1;
          else begin
            cur  = tx_byte >> (b - 1);
            line = cur[0];
          end
          for (int c = 0; c < CPB; c++) begin
            if (reset === 1'b1) aborted = 1'b1;
            if (!aborted && tx_byte !== fb) unstable++;
            @(posedge clock);
            #1;
          end
        end
        tx_done = 1'b1;
      end
    end
  end

  // Line monitor: decodes 8N1 frames by sampling mid-bit.
  initial begin : mon
    logic [7:0] d;
    d = 8'h00;
    forever begin
      @(negedge clock);
      if (line === 1'b0) begin
        repeat (CPB / 2) @(negedge clock);
        for (int b = 0; b < 9; b++) begin
          repeat (CPB) @(negedge clock);
          if (b < 8) d = {line, d[7:1]};
          else if (line !== 1'b1) framing_err++;
        end
        rx_q.push_back(d);
      end
    end
  end

  initial begin : main
    int n;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;

    // reset and hold-off length
    tick();
    reset = 1'b0;
    check("rst_empty",   32'(empty),   32'(1));
    check("rst_full",    32'(full),    32'(0));
    check("rst_tx_send", 32'(tx_send), 32'(0));
    check("rst_tx_byte", 32'(tx_byte), 32'(8'h00));
    check("rst_busy",    32'(busy),    32'(1));
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("holdoff_len", 32'(n), 32'(HOLD));

    // single byte: empty drops on the push edge, send one edge later
    push_byte(8'hA5);
    check("a5_not_empty", 32'(empty),   32'(0));
    check("a5_no_send",   32'(tx_send), 32'(0));
    tick();
    check("a5_send",      32'(tx_send), 32'(1));
    check("a5_byte",      32'(tx_byte), 32'(8'hA5));

    // five back-to-back pushes while A5 is on the line: fourth fills, fifth overflows
    for (int i = 0; i < 5; i++) begin
      push_byte(8'(17 * (i + 1)));
      if (i == 3) check("full_after_4th", 32'(full),     32'(1));
      if (i == 4) check("ovf_on_5th",     32'(overflow), 32'(1));
    end
    tick();
    check("ovf_one_cycle", 32'(overflow), 32'(0));

    // gap from transmitter done to next send
    n = 0;
    while (tx_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("done_seen", 32'(tx_done), 32'(1));
    n = 0;
    do begin
      tick();
      n++;
    end while (tx_send !== 1'b1 && n < 10);
    check("send_gap", 32'(n), 32'(2));
    drain();
    wait_rx_and_compare();

    // reset mid-frame: stale done during hold-off must be ignored
    push_byte(8'hAA);
    n = 0;
    while (tx_send !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("aa_send", 32'(tx_send), 32'(1));
    repeat (20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sent_dc[sent_dc.size() - 1] = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("holdoff_after_abort", 32'(n), 32'(HOLD));
    push_byte(8'h3C);
    drain();
    wait_rx_and_compare();

    // randomized traffic, starting with pushes during hold-off
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 800; i++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_data = 8'($urandom);
      tick();
    end
    wr_en = 1'b0;
    drain();
    wait_rx_and_compare();

    check("byte_stable", 32'(unstable),    32'(0));
    check("framing",     32'(framing_err), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
